tof_readout_scheduler: RTL and testbench

Round-robin readout scheduler for the eight ToF I2C channels. It latches the per-channel `ready_in` flags and drives `tof_index` to select one channel at a time. It captures the selected 22-bit `{sensor_index, distance}` word and delivers it on a valid/ready stream tagged with the channel number. A per-channel watchdog flags sensors that have produced no capture within a configurable number of cycles. It sits between the ToF comm-module array and the downstream packetiser.

---
 rtl/tof_readout_scheduler_if.sv | 10 +
 rtl/tof_readout_scheduler.sv | 134 +++++++++++++
 tb/tb_tof_readout_scheduler.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tof_readout_scheduler_if.sv
// Valid/ready output stream carrying a captured ToF word and its source channel.
interface tof_readout_scheduler_if;
  logic        m_valid;
  logic        m_ready;
  logic [21:0] m_data;
  logic [2:0]  m_channel;

  modport master (output m_valid, output m_data, output m_channel, input m_ready);
  modport slave  (input m_valid, input m_data, input m_channel, output m_ready);
endinterface

// File: rtl/tof_readout_scheduler.sv
// Round-robin readout scheduler for eight ToF channels: latches ready flags, selects one
// channel at a time, streams the captured word out, and watches each channel for silence.
module tof_readout_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000,
  parameter int unsigned TW             = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 ready_in,
  input  logic [21:0]                data_in,
  input  logic [7:0]                 enable,
  output logic [2:0]                 tof_index,
  tof_readout_scheduler_if.master    m,
  output logic [7:0]                 stale,
  output logic                       busy
);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_CAPTURE, S_OUT} state_t;

  localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] ONE = TW'(1);

  state_t          state_q, state_d;
  logic [7:0]      pending;
  logic [2:0]      last_grant;
  logic [2:0]      grant_ch;
  logic            grant_found;
  logic [2:0]      cand;
  logic            do_grant, do_capture, do_pop;
  logic [7:0]      cap_mask;
  logic            valid_q;
  logic [21:0]     data_q;
  logic [2:0]      chan_q;
  logic [TW-1:0]   cnt [8];

  assign m.m_valid   = valid_q;
  assign m.m_data    = data_q;
  assign m.m_channel = chan_q;
  assign busy        = (state_q != S_IDLE);

  // First pending channel strictly after last_grant, wrapping mod 8.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = last_grant;
    cand        = '0;
    for (int unsigned k = 1; k <= 8; k++) begin
      cand = last_grant + 3'(k);
      if (!grant_found && pending[cand]) begin
        grant_found = 1'b1;
        grant_ch    = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    do_grant   = 1'b0;
    do_capture = 1'b0;
    do_pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          do_grant = 1'b1;
          state_d  = S_SELECT;
        end
      end
      S_SELECT:  state_d = S_CAPTURE;
      S_CAPTURE: begin
        do_capture = 1'b1;
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (m.m_ready) begin
          do_pop  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cap_mask = do_capture ? (8'b1 << tof_index) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending    <= '0;
      last_grant <= 3'd7;
      tof_index  <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      chan_q     <= '0;
    end else begin
      // Capture clear beats a same-cycle set so the flag still being dropped is not re-read.
      pending <= (pending | ready_in) & enable & ~cap_mask;
      if (do_grant) begin
        tof_index  <= grant_ch;
        last_grant <= grant_ch;
      end
      if (do_capture) begin
        data_q  <= data_in;
        chan_q  <= tof_index;
        valid_q <= 1'b1;
      end else if (do_pop) begin
        valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 8; i++) cnt[i] <= '0;
      stale <= '0;
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (!enable[i]) begin
          cnt[i]   <= '0;
          stale[i] <= 1'b0;
        end else if (cap_mask[i]) begin
          cnt[i]   <= '0;
          stale[i] <= 1'b0;
        end else if (cnt[i] < TMO) begin
          cnt[i] <= cnt[i] + ONE;
          if (cnt[i] == TMO - ONE) stale[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tof_readout_scheduler.sv
// Directed bench for tof_readout_scheduler with a scoreboard of expected output words.
module tb_tof_readout_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  ready_in;
  logic [21:0] data_in;
  logic [7:0]  enable;
  logic [2:0]  tof_index;
  logic [7:0]  stale;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [2:0]  ch;
    logic [21:0] data;
  } exp_t;
  exp_t q[$];

  tof_readout_scheduler_if m_if ();

  tof_readout_scheduler #(.TIMEOUT_CYCLES(16), .TW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .ready_in  (ready_in),
    .data_in   (data_in),
    .enable    (enable),
    .tof_index (tof_index),
    .m         (m_if.master),
    .stale     (stale),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [21:0] word(input logic [2:0] ch);
    logic [5:0]  s;
    logic [15:0] d;
    s = {1'b0, ch, 2'b00};
    d = 16'h1231 + 16'(ch);
    return {s, d};
  endfunction

  assign data_in = word(tof_index);

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] ch);
    exp_t e;
    e.ch   = ch;
    e.data = word(ch);
    q.push_back(e);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (m_if.m_valid !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, {31'd0, m_if.m_valid}, 32'd1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, q.size(), 0);
  endtask

  // Scoreboard pops on every accepted word; a stalled word must hold steady.
  logic        prev_hold = 1'b0;
  logic [21:0] prev_d;
  logic [2:0]  prev_c;
  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        checks++;
        assert (m_if.m_valid === 1'b1 && m_if.m_data === prev_d && m_if.m_channel === prev_c)
        else begin
          errors++;
          $error("FAIL stall_stable: observed v=%b d=0x%0h c=%0d expected v=1 d=0x%0h c=%0d",
                 m_if.m_valid, m_if.m_data, m_if.m_channel, prev_d, prev_c);
        end
      end
      if (m_if.m_valid === 1'b1 && m_if.m_ready === 1'b1) begin
        checks++;
        assert (q.size() != 0)
        else begin
          errors++;
          $error("FAIL sb_unexpected: observed c=%0d d=0x%0h expected no word",
                 m_if.m_channel, m_if.m_data);
        end
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          checks++;
          assert (m_if.m_channel === e.ch && m_if.m_data === e.data)
          else begin
            errors++;
            $error("FAIL sb_word: observed c=%0d d=0x%0h expected c=%0d d=0x%0h",
                   m_if.m_channel, m_if.m_data, e.ch, e.data);
          end
        end
      end
      prev_hold = (m_if.m_valid === 1'b1) && (m_if.m_ready !== 1'b1);
      prev_d    = m_if.m_data;
      prev_c    = m_if.m_channel;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int t_prev;
    reset       = 1'b1;
    ready_in    = '0;
    enable      = 8'hFF;
    m_if.m_ready = 1'b0;
    t_prev      = 0;

    // Reset values
    step(2);
    chk("rst_tof_index", tof_index, 0);
    chk("rst_m_valid", m_if.m_valid, 0);
    chk("rst_m_data", m_if.m_data, 0);
    chk("rst_m_channel", m_if.m_channel, 0);
    chk("rst_stale", stale, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    step(1);

    // Single request on channel 3: latency
    m_if.m_ready = 1'b1;
    ready_in = 8'h08;
    push(3);
    step(1);
    ready_in = '0;
    step(1);
    chk("lat_tof_index", tof_index, 3);
    chk("lat_busy", busy, 1);
    step(1);
    chk("lat_valid_n3", m_if.m_valid, 0);
    step(1);
    chk("lat_valid_n4", m_if.m_valid, 1);
    chk("lat_data", m_if.m_data, 32'h0C1234);
    chk("lat_channel", m_if.m_channel, 3);
    step(1);
    chk("lat_idle", {m_if.m_valid, busy}, 0);

    // All channels held ready: strict rotation, 4 cycles per word
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) push(3'(i));
    ready_in = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      wait_valid("rr_valid", 12);
      chk("rr_channel", m_if.m_channel, i);
      if (i > 0) chk("rr_gap", cyc - t_prev, 4);
      t_prev = cyc;
      if (i == 7) begin
        ready_in = '0;
        enable   = '0;
      end
      step(1);
    end
    enable = 8'hFF;
    step(3);
    chk("rr_done_busy", busy, 0);
    chk("rr_drained", q.size(), 0);

    // Backpressure: word held 20 cycles while two more channels arrive
    m_if.m_ready = 1'b0;
    ready_in = 8'h20;
    push(5);
    step(1);
    ready_in = '0;
    wait_valid("stall_valid", 10);
    for (int k = 0; k < 20; k++) begin
      if (k == 3) begin
        ready_in = 8'h44;
        push(6);
        push(2);
      end
      if (k == 4) ready_in = '0;
      step(1);
      chk("stall_hold", {m_if.m_valid, 4'd0, m_if.m_channel, 2'd0, m_if.m_data},
          {1'b1, 4'd0, 3'd5, 2'd0, word(3'd5)});
    end
    m_if.m_ready = 1'b1;
    wait_drain("stall_drain", 40);

    // Disabled channel is ignored, re-enabled channel is served
    enable = 8'hFE;
    ready_in = 8'h01;
    step(1);
    ready_in = '0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      chk("dis_no_out", {m_if.m_valid, busy}, 0);
    end
    enable = 8'hFF;
    ready_in = 8'h01;
    push(0);
    step(1);
    ready_in = '0;
    wait_drain("dis_drain", 20);

    // Reset during CAPTURE
    ready_in = 8'h10;
    step(1);
    ready_in = '0;
    step(2);
    chk("midrst_pre_busy", busy, 1);
    chk("midrst_pre_index", tof_index, 4);
    reset = 1'b1;
    #1;
    chk("midrst_valid", m_if.m_valid, 0);
    chk("midrst_index", tof_index, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_data", m_if.m_data, 0);
    step(1);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      chk("midrst_no_pending", {m_if.m_valid, busy}, 0);
    end
    ready_in = 8'h40;
    push(6);
    step(1);
    ready_in = '0;
    step(1);
    chk("midrst_fresh_index", tof_index, 6);
    wait_drain("midrst_drain", 20);

    // Watchdog with TIMEOUT_CYCLES=16 on channel 0 only
    enable = 8'h01;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(15);
    chk("wd_edge15", stale, 8'h00);
    step(1);
    chk("wd_edge16", stale, 8'h01);
    ready_in = 8'h01;
    push(0);
    step(1);
    ready_in = '0;
    step(2);
    chk("wd_sticky", stale, 8'h01);
    step(1);
    chk("wd_cleared", stale, 8'h00);
    step(15);
    chk("wd_rerise_pre", stale, 8'h00);
    step(1);
    chk("wd_rerise", stale, 8'h01);
    enable = 8'h00;
    step(1);
    chk("wd_disable", stale, 8'h00);
    chk("final_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
